// File: rtl/ahbl_arbiter_2m1s.sv
// ahbl_arbiter_2m1s
// Two-master to one-slave AHB-Lite arbiter. Source 0 (load/store) has fixed
// priority over source 1 (fetch). Each source can have at most one transfer
// outstanding. An address phase that cannot be issued in the cycle it is
// presented is captured and replayed later, so no source ever sees a
// transfer dropped.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   srcN_haddr/hwrite/htrans/  upstream address phase for sources 0 and 1
//   hsize/hwdata               (only htrans[1] is decoded)
//   srcN_hready/hresp/hrdata   upstream response for sources 0 and 1
//   dst_haddr/hwrite/htrans/   downstream address phase
//   hsize/hburst/hprot/
//   hmastlock
//   dst_hwdata                 write data of the current data-phase owner
//   dst_hready/hresp/hrdata    downstream slave response
module ahbl_arbiter_2m1s #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [W_ADDR-1:0] src0_haddr,
  input  logic              src0_hwrite,
  input  logic [1:0]        src0_htrans,
  input  logic [2:0]        src0_hsize,
  input  logic [W_DATA-1:0] src0_hwdata,
  output logic              src0_hready,
  output logic              src0_hresp,
  output logic [W_DATA-1:0] src0_hrdata,

  input  logic [W_ADDR-1:0] src1_haddr,
  input  logic              src1_hwrite,
  input  logic [1:0]        src1_htrans,
  input  logic [2:0]        src1_hsize,
  input  logic [W_DATA-1:0] src1_hwdata,
  output logic              src1_hready,
  output logic              src1_hresp,
  output logic [W_DATA-1:0] src1_hrdata,

  output logic [W_ADDR-1:0] dst_haddr,
  output logic              dst_hwrite,
  output logic [1:0]        dst_htrans,
  output logic [2:0]        dst_hsize,
  output logic [2:0]        dst_hburst,
  output logic [3:0]        dst_hprot,
  output logic              dst_hmastlock,
  output logic [W_DATA-1:0] dst_hwdata,
  input  logic              dst_hready,
  input  logic              dst_hresp,
  input  logic [W_DATA-1:0] dst_hrdata
);

  typedef enum logic [1:0] {
    ST_IDLE,  // nothing owed to this source
    ST_HELD,  // address phase captured, waiting for the bus
    ST_DPH    // issued, downstream data phase in progress
  } src_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_SRC0,
    OWN_SRC1
  } owner_e;

  // Per-source views of the upstream inputs, indexed 0/1.
  logic [W_ADDR-1:0] in_addr  [2];
  logic [2:0]        in_size  [2];
  logic [1:0]        in_write;
  logic [1:0]        in_active;

  // Only htrans[1] distinguishes IDLE/BUSY from NSEQ/SEQ.
  logic unused_htrans0;
  assign unused_htrans0 = src0_htrans[0] ^ src1_htrans[0];

  always_comb begin
    in_addr[0]   = src0_haddr;
    in_addr[1]   = src1_haddr;
    in_size[0]   = src0_hsize;
    in_size[1]   = src1_hsize;
    in_write     = {src1_hwrite, src0_hwrite};
    in_active    = {src1_htrans[1], src0_htrans[1]};
  end

  // State and held address-phase registers.
  src_state_e        state_q    [2];
  src_state_e        state_d    [2];
  logic [W_ADDR-1:0] held_addr_q [2];
  logic [W_ADDR-1:0] held_addr_d [2];
  logic [2:0]        held_size_q [2];
  logic [2:0]        held_size_d [2];
  logic [1:0]        held_write_q;
  logic [1:0]        held_write_d;

  owner_e            owner_q, owner_d;
  logic              lock_q, lock_d;
  logic              lock_src_q, lock_src_d;

  // Candidate and grant signals.
  logic [1:0]        hready_src;
  logic [1:0]        live;
  logic [1:0]        cand;
  logic [W_ADDR-1:0] cand_addr  [2];
  logic [2:0]        cand_size  [2];
  logic [1:0]        cand_write;
  logic              gnt_valid;
  logic              gnt_src;
  logic [1:0]        issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        state_q[i]     <= ST_IDLE;
        held_addr_q[i] <= '0;
        held_size_q[i] <= '0;
      end
      held_write_q <= '0;
      owner_q      <= OWN_NONE;
      lock_q       <= 1'b0;
      lock_src_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        state_q[i]     <= state_d[i];
        held_addr_q[i] <= held_addr_d[i];
        held_size_q[i] <= held_size_d[i];
      end
      held_write_q <= held_write_d;
      owner_q      <= owner_d;
      lock_q       <= lock_d;
      lock_src_q   <= lock_src_d;
    end
  end

  // Upstream hready and candidate selection.
  always_comb begin
    hready_src = '0;
    live       = '0;
    cand       = '0;
    cand_write = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      cand_addr[i] = '0;
      cand_size[i] = '0;
    end
    for (int unsigned i = 0; i < 2; i++) begin
      case (state_q[i])
        ST_IDLE: hready_src[i] = 1'b1;
        ST_DPH:  hready_src[i] = dst_hready;
        default: hready_src[i] = 1'b0;
      endcase
      live[i] = hready_src[i] & in_active[i];
      if (state_q[i] == ST_HELD) begin
        cand[i]       = 1'b1;
        cand_addr[i]  = held_addr_q[i];
        cand_size[i]  = held_size_q[i];
        cand_write[i] = held_write_q[i];
      end else begin
        cand[i]       = live[i];
        cand_addr[i]  = in_addr[i];
        cand_size[i]  = in_size[i];
        cand_write[i] = in_write[i];
      end
    end
  end

  // Grant: a stalled address phase keeps the bus (its source is HELD by
  // then, so the replayed values are identical); otherwise fixed priority.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_src   = 1'b0;
    if (lock_q) begin
      gnt_valid = cand[lock_src_q];
      gnt_src   = lock_src_q;
    end else if (cand[0]) begin
      gnt_valid = 1'b1;
      gnt_src   = 1'b0;
    end else if (cand[1]) begin
      gnt_valid = 1'b1;
      gnt_src   = 1'b1;
    end
    issue[0] = gnt_valid & (gnt_src == 1'b0) & dst_hready;
    issue[1] = gnt_valid & (gnt_src == 1'b1) & dst_hready;
  end

  // Next-state for sources, held registers, owner and lock.
  always_comb begin
    held_write_d = held_write_q;
    for (int unsigned i = 0; i < 2; i++) begin
      state_d[i]     = state_q[i];
      held_addr_d[i] = held_addr_q[i];
      held_size_d[i] = held_size_q[i];
      if (issue[i]) begin
        state_d[i] = ST_DPH;
      end else if (live[i]) begin
        state_d[i]      = ST_HELD;
        held_addr_d[i]  = in_addr[i];
        held_size_d[i]  = in_size[i];
        held_write_d[i] = in_write[i];
      end else if (state_q[i] == ST_DPH && dst_hready) begin
        state_d[i] = ST_IDLE;
      end
    end

    owner_d = owner_q;
    if (dst_hready) begin
      if (issue[0])      owner_d = OWN_SRC0;
      else if (issue[1]) owner_d = OWN_SRC1;
      else               owner_d = OWN_NONE;
    end

    lock_d     = gnt_valid & ~dst_hready;
    lock_src_d = lock_d ? gnt_src : 1'b0;
  end

  // Downstream address phase.
  always_comb begin
    dst_haddr  = '0;
    dst_hwrite = 1'b0;
    dst_hsize  = '0;
    dst_htrans = 2'b00;
    if (gnt_valid) begin
      dst_haddr  = cand_addr[gnt_src];
      dst_hwrite = cand_write[gnt_src];
      dst_hsize  = cand_size[gnt_src];
      dst_htrans = 2'b10;
    end
  end

  assign dst_hburst    = 3'h0;
  assign dst_hprot     = 4'b0010;
  assign dst_hmastlock = 1'b0;

  // Data phase follows the registered owner.
  always_comb begin
    dst_hwdata = '0;
    src0_hresp = 1'b0;
    src1_hresp = 1'b0;
    case (owner_q)
      OWN_SRC0: begin
        dst_hwdata = src0_hwdata;
        src0_hresp = dst_hresp;
      end
      OWN_SRC1: begin
        dst_hwdata = src1_hwdata;
        src1_hresp = dst_hresp;
      end
      default: ;
    endcase
  end

  assign src0_hready = hready_src[0];
  assign src1_hready = hready_src[1];
  assign src0_hrdata = dst_hrdata;
  assign src1_hrdata = dst_hrdata;

endmodule

// File: tb/tb_ahbl_arbiter_2m1s.sv
// Directed testbench for ahbl_arbiter_2m1s. Inputs change 1 time unit after
// the rising edge; outputs are checked on the falling edge.
module tb_ahbl_arbiter_2m1s;

  localparam int W_ADDR = 32;
  localparam int W_DATA = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [W_ADDR-1:0] src0_haddr, src1_haddr;
  logic              src0_hwrite, src1_hwrite;
  logic [1:0]        src0_htrans, src1_htrans;
  logic [2:0]        src0_hsize, src1_hsize;
  logic [W_DATA-1:0] src0_hwdata, src1_hwdata;
  logic              src0_hready, src1_hready;
  logic              src0_hresp, src1_hresp;
  logic [W_DATA-1:0] src0_hrdata, src1_hrdata;
  logic [W_ADDR-1:0] dst_haddr;
  logic              dst_hwrite;
  logic [1:0]        dst_htrans;
  logic [2:0]        dst_hsize;
  logic [2:0]        dst_hburst;
  logic [3:0]        dst_hprot;
  logic              dst_hmastlock;
  logic [W_DATA-1:0] dst_hwdata;
  logic              dst_hready;
  logic              dst_hresp;
  logic [W_DATA-1:0] dst_hrdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ahbl_arbiter_2m1s #(
    .W_ADDR(W_ADDR),
    .W_DATA(W_DATA)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .src0_haddr(src0_haddr), .src0_hwrite(src0_hwrite), .src0_htrans(src0_htrans),
    .src0_hsize(src0_hsize), .src0_hwdata(src0_hwdata), .src0_hready(src0_hready),
    .src0_hresp(src0_hresp), .src0_hrdata(src0_hrdata),
    .src1_haddr(src1_haddr), .src1_hwrite(src1_hwrite), .src1_htrans(src1_htrans),
    .src1_hsize(src1_hsize), .src1_hwdata(src1_hwdata), .src1_hready(src1_hready),
    .src1_hresp(src1_hresp), .src1_hrdata(src1_hrdata),
    .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
    .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
    .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata), .dst_hready(dst_hready),
    .dst_hresp(dst_hresp), .dst_hrdata(dst_hrdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle's drive point.
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    src0_htrans = 2'b00;
    src1_htrans = 2'b00;
    src0_hwrite = 1'b0;
    src1_hwrite = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    src0_haddr  = '0; src1_haddr  = '0;
    src0_hsize  = 3'd2; src1_hsize = 3'd2;
    src0_hwdata = '0; src1_hwdata = '0;
    idle_inputs();
    dst_hready  = 1'b1;
    dst_hresp   = 1'b0;
    dst_hrdata  = '0;

    // Reset state
    @(negedge clk);
    chk("rst_htrans", 64'(dst_htrans), 64'h0);
    chk("rst_src0_hready", 64'(src0_hready), 64'h1);
    chk("rst_src1_hready", 64'(src1_hready), 64'h1);
    chk("rst_src0_hresp", 64'(src0_hresp), 64'h0);
    chk("rst_src1_hresp", 64'(src1_hresp), 64'h0);
    chk("rst_hwdata", 64'(dst_hwdata), 64'h0);
    chk("const_hburst", 64'(dst_hburst), 64'h0);
    chk("const_hprot", 64'(dst_hprot), 64'h2);
    chk("const_hmastlock", 64'(dst_hmastlock), 64'h0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // src1 read 0x100, zero-wait slave
    src1_haddr = 32'h100; src1_htrans = 2'b10;
    @(negedge clk);
    chk("s1rd_haddr", 64'(dst_haddr), 64'h100);
    chk("s1rd_htrans", 64'(dst_htrans), 64'h2);
    chk("s1rd_hwrite", 64'(dst_hwrite), 64'h0);
    chk("s1rd_hsize", 64'(dst_hsize), 64'h2);
    chk("s1rd_hready_a", 64'(src1_hready), 64'h1);
    next_cycle();
    idle_inputs();
    dst_hrdata = 32'h1234_5678;
    @(negedge clk);
    chk("s1rd_hrdata", 64'(src1_hrdata), 64'h1234_5678);
    chk("s1rd_hready_d", 64'(src1_hready), 64'h1);
    chk("s1rd_htrans_d", 64'(dst_htrans), 64'h0);
    next_cycle();

    // Contention: src0 write 0x200, src1 read 0x300
    src0_haddr = 32'h200; src0_hwrite = 1'b1; src0_htrans = 2'b10;
    src1_haddr = 32'h300; src1_htrans = 2'b10;
    @(negedge clk);
    chk("cont_haddr0", 64'(dst_haddr), 64'h200);
    chk("cont_hwrite0", 64'(dst_hwrite), 64'h1);
    chk("cont_src1_hready_a", 64'(src1_hready), 64'h1);
    next_cycle();
    idle_inputs();
    src0_haddr = 32'hDEAD; src1_haddr = 32'hBEEF;
    src0_hwdata = 32'hA5A5_A5A5; src1_hwdata = 32'h0000_1111;
    @(negedge clk);
    chk("cont_haddr1", 64'(dst_haddr), 64'h300);
    chk("cont_hwrite1", 64'(dst_hwrite), 64'h0);
    chk("cont_htrans1", 64'(dst_htrans), 64'h2);
    chk("cont_hwdata0", 64'(dst_hwdata), 64'hA5A5_A5A5);
    chk("cont_src1_hready_held", 64'(src1_hready), 64'h0);
    chk("cont_src0_hready", 64'(src0_hready), 64'h1);
    next_cycle();
    @(negedge clk);
    chk("cont_src1_hready_d", 64'(src1_hready), 64'h1);
    chk("cont_htrans_idle", 64'(dst_htrans), 64'h0);
    chk("cont_hwdata1", 64'(dst_hwdata), 64'h0000_1111);
    next_cycle();
    @(negedge clk);
    chk("cont_hwdata_none", 64'(dst_hwdata), 64'h0);
    next_cycle();

    // Grant lock across two wait states
    src1_haddr = 32'h500; src1_htrans = 2'b10; dst_hready = 1'b0;
    @(negedge clk);
    chk("lock_haddr_w1", 64'(dst_haddr), 64'h500);
    chk("lock_htrans_w1", 64'(dst_htrans), 64'h2);
    next_cycle();
    src1_htrans = 2'b00; src1_haddr = 32'hFFF0;
    src0_haddr = 32'h600; src0_htrans = 2'b10;
    @(negedge clk);
    chk("lock_haddr_w2", 64'(dst_haddr), 64'h500);
    chk("lock_src0_hready_w2", 64'(src0_hready), 64'h1);
    chk("lock_src1_hready_w2", 64'(src1_hready), 64'h0);
    next_cycle();
    src0_htrans = 2'b00; src0_haddr = 32'hFFF4; dst_hready = 1'b1;
    @(negedge clk);
    chk("lock_haddr_rdy", 64'(dst_haddr), 64'h500);
    chk("lock_src0_hready_held", 64'(src0_hready), 64'h0);
    next_cycle();
    @(negedge clk);
    chk("lock_haddr_after", 64'(dst_haddr), 64'h600);
    chk("lock_htrans_after", 64'(dst_htrans), 64'h2);
    chk("lock_src1_hready_dph", 64'(src1_hready), 64'h1);
    next_cycle();
    @(negedge clk);
    chk("lock_idle", 64'(dst_htrans), 64'h0);
    next_cycle();

    // Back-to-back src0 transfers
    src0_haddr = 32'h10; src0_htrans = 2'b10;
    @(negedge clk);
    chk("b2b_haddr0", 64'(dst_haddr), 64'h10);
    next_cycle();
    src0_haddr = 32'h14; src0_hwdata = 32'h5555_0001;
    @(negedge clk);
    chk("b2b_haddr1", 64'(dst_haddr), 64'h14);
    chk("b2b_src0_hready", 64'(src0_hready), 64'h1);
    chk("b2b_hwdata", 64'(dst_hwdata), 64'h5555_0001);
    next_cycle();
    idle_inputs();
    next_cycle();

    // Slave error on src0 read 0x400
    src0_haddr = 32'h400; src0_htrans = 2'b10;
    @(negedge clk);
    chk("err_haddr", 64'(dst_haddr), 64'h400);
    next_cycle();
    idle_inputs();
    dst_hready = 1'b0; dst_hresp = 1'b1;
    @(negedge clk);
    chk("err_src0_hresp1", 64'(src0_hresp), 64'h1);
    chk("err_src0_hready1", 64'(src0_hready), 64'h0);
    chk("err_src1_hresp1", 64'(src1_hresp), 64'h0);
    next_cycle();
    dst_hready = 1'b1;
    @(negedge clk);
    chk("err_src0_hresp2", 64'(src0_hresp), 64'h1);
    chk("err_src0_hready2", 64'(src0_hready), 64'h1);
    chk("err_src1_hresp2", 64'(src1_hresp), 64'h0);
    next_cycle();
    dst_hresp = 1'b0;
    @(negedge clk);
    chk("err_src0_hresp_end", 64'(src0_hresp), 64'h0);
    next_cycle();

    // Reset while src1 is HELD
    src0_haddr = 32'h700; src0_htrans = 2'b10;
    src1_haddr = 32'h300; src1_htrans = 2'b10;
    next_cycle();
    idle_inputs();
    dst_hready = 1'b0;
    @(negedge clk);
    chk("rstmid_src1_held", 64'(src1_hready), 64'h0);
    chk("rstmid_haddr_pre", 64'(dst_haddr), 64'h300);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_htrans", 64'(dst_htrans), 64'h0);
    chk("rstmid_src0_hready", 64'(src0_hready), 64'h1);
    chk("rstmid_src1_hready", 64'(src1_hready), 64'h1);
    chk("rstmid_hwdata", 64'(dst_hwdata), 64'h0);
    next_cycle();
    rst_n = 1'b1;
    dst_hready = 1'b1;
    @(negedge clk);
    chk("rstmid_post_htrans1", 64'(dst_htrans), 64'h0);
    next_cycle();
    @(negedge clk);
    chk("rstmid_post_htrans2", 64'(dst_htrans), 64'h0);
    chk("rstmid_post_src1_hready", 64'(src1_hready), 64'h1);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
